// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter slice.
package button_event_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEFAULT_SAMPLE_CNT_MAX = 62500;
  localparam int DEFAULT_PULSE_CNT_MAX  = 200;

  // Counter width able to hold values 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: saturating high-sample counter, debounced level and press edge.
module debounce_cell
  import button_event_arbiter_pkg::*;
#(
  parameter int PULSE_CNT_MAX = DEFAULT_PULSE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_s,
  input  logic tick,
  output logic press
);

  localparam int            CW      = cnt_width(PULSE_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(PULSE_CNT_MAX);

  logic [CW-1:0] cnt;
  logic          db;
  logic          db_q;

  // A low sample clears the count at once; highs only count on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db_q <= 1'b0;
    end else begin
      if (!btn_s) begin
        cnt <= '0;
      end else if (tick && (cnt != CNT_TOP)) begin
        cnt <= cnt + 1'b1;
      end
      db_q <= db;
    end
  end

  assign db    = (cnt == CNT_TOP);
  assign press = db & ~db_q;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a vector of independent asynchronous levels.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N buttons and offers each press once over valid/ready, round-robin between buttons.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX,
  parameter int IDX_W          = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_async,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [N_BTN-1:0] pending,
  output logic             overrun
);

  localparam int             SCW        = cnt_width(SAMPLE_CNT_MAX);
  localparam logic [SCW-1:0] SAMPLE_TOP = SCW'(SAMPLE_CNT_MAX - 1);

  logic [N_BTN-1:0] btn_s;
  logic [SCW-1:0]   sample_cnt;
  logic             tick;
  logic [N_BTN-1:0] press;

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] rr, rr_next;
  logic [N_BTN-1:0] clear;
  logic [N_BTN-1:0] pending_next;
  logic             overrun_next;
  logic             found;
  logic [IDX_W-1:0] pick;

  synchronizer #(
    .WIDTH(N_BTN)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_async),
    .q    (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  assign tick = (sample_cnt == SAMPLE_TOP);

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .PULSE_CNT_MAX(PULSE_CNT_MAX)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_s(btn_s[i]),
      .tick (tick),
      .press(press[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      evt_idx <= '0;
      rr      <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      evt_idx <= idx_next;
      rr      <= rr_next;
      pending <= pending_next;
      overrun <= overrun_next;
    end
  end

  // Round-robin pick starts at rr and wraps; acceptance frees the slot and advances rr.
  always_comb begin
    state_next = state;
    idx_next   = evt_idx;
    rr_next    = rr;
    clear      = '0;
    found      = 1'b0;
    pick       = '0;

    for (int k = 0; k < N_BTN; k++) begin
      int pos;
      pos = (int'(rr) + k) % N_BTN;
      if (!found && pending[pos]) begin
        found = 1'b1;
        pick  = IDX_W'(pos);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_next = OFFER;
          idx_next   = pick;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_next     = IDLE;
          clear[evt_idx] = 1'b1;
          rr_next        = (int'(evt_idx) == N_BTN - 1) ? '0 : evt_idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    pending_next = (pending & ~clear) | press;
    overrun_next = |(press & pending & ~clear);
  end

  assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench: reset latency, backpressure, round-robin, overrun, bounce, mid-offer reset.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_a, btn_b;
  logic       ready_a, ready_b;
  logic       valid_a, valid_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] pending_a, pending_b;
  logic       overrun_a, overrun_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN(4), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_async(btn_a), .evt_valid(valid_a),
    .evt_ready(ready_a), .evt_idx(idx_a), .pending(pending_a), .overrun(overrun_a)
  );

  button_event_arbiter #(
    .N_BTN(4), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_async(btn_b), .evt_valid(valid_b),
    .evt_ready(ready_b), .evt_idx(idx_b), .pending(pending_b), .overrun(overrun_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] btn, input logic ready);
    btn_a   = btn;
    ready_a = ready;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    btn_b = 4'b0000;
    ready_b = 1'b0;
    apply_stimulus(4'b1111, 1'b0);
    step(3);
    check_output("rst_valid", 32'(valid_a), 32'h0);
    check_output("rst_idx", 32'(idx_a), 32'h0);
    check_output("rst_pending", 32'(pending_a), 32'h0);
    check_output("rst_overrun", 32'(overrun_a), 32'h0);

    #4 rst_n = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step(1);
      check_output("lat_valid_low", 32'(valid_a), 32'h0);
      if (e == 3) check_output("lat_pending_e3", 32'(pending_a), 32'h0);
    end
    check_output("lat_pending_e4", 32'(pending_a), 32'hF);
    step(1);
    check_output("lat_valid_e5", 32'(valid_a), 32'h1);
    check_output("lat_idx_e5", 32'(idx_a), 32'h0);

    for (int c = 0; c < 20; c++) begin
      step(1);
      check_output("bp_valid", 32'(valid_a), 32'h1);
      check_output("bp_idx", 32'(idx_a), 32'h0);
    end
    apply_stimulus(4'b1111, 1'b1);
    step(1);
    check_output("bp_accept_valid", 32'(valid_a), 32'h0);
    check_output("bp_accept_pending", 32'(pending_a), 32'hE);
    apply_stimulus(4'b1111, 1'b0);
    step(1);
    check_output("bp_next_idx", 32'(idx_a), 32'h1);
    check_output("bp_next_valid", 32'(valid_a), 32'h1);

    rst_n = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(1);
    apply_stimulus(4'b1011, 1'b1);
    step(5);
    check_output("rr_pending", 32'(pending_a), 32'hB);
    check_output("rr_rr_start", 32'(dut.rr), 32'h0);
    step(1);
    check_output("rr_idx0", 32'(idx_a), 32'h0);
    step(2);
    check_output("rr_idx1", 32'(idx_a), 32'h1);
    check_output("rr_valid1", 32'(valid_a), 32'h1);
    step(2);
    check_output("rr_idx3", 32'(idx_a), 32'h3);
    step(1);
    check_output("rr_rr_end", 32'(dut.rr), 32'h0);
    check_output("rr_pending_end", 32'(pending_a), 32'h0);
    check_output("rr_valid_end", 32'(valid_a), 32'h0);

    apply_stimulus(4'b0000, 1'b0);
    step(4);
    apply_stimulus(4'b0010, 1'b0);
    step(6);
    check_output("ovr_first_idx", 32'(idx_a), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    step(4);
    apply_stimulus(4'b0010, 1'b0);
    step(4);
    check_output("ovr_before", 32'(overrun_a), 32'h0);
    step(1);
    check_output("ovr_pulse", 32'(overrun_a), 32'h1);
    check_output("ovr_pending_kept", 32'(pending_a), 32'h2);
    step(1);
    check_output("ovr_one_cycle", 32'(overrun_a), 32'h0);
    apply_stimulus(4'b0010, 1'b1);
    step(1);
    check_output("ovr_accept_pending", 32'(pending_a), 32'h0);
    apply_stimulus(4'b0010, 1'b0);
    step(4);
    check_output("ovr_single_event", 32'(valid_a), 32'h0);

    apply_stimulus(4'b0000, 1'b0);
    step(4);
    apply_stimulus(4'b0010, 1'b0);
    step(6);
    check_output("coin_first_idx", 32'(idx_a), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    step(4);
    apply_stimulus(4'b0010, 1'b0);
    step(4);
    apply_stimulus(4'b0010, 1'b1);
    step(1);
    check_output("coin_valid_drop", 32'(valid_a), 32'h0);
    check_output("coin_pending_set", 32'(pending_a), 32'h2);
    check_output("coin_no_overrun", 32'(overrun_a), 32'h0);
    step(1);
    check_output("coin_second_valid", 32'(valid_a), 32'h1);
    check_output("coin_second_idx", 32'(idx_a), 32'h1);
    step(1);
    check_output("coin_second_done", 32'(pending_a), 32'h0);
    apply_stimulus(4'b0000, 1'b0);

    step(4);
    apply_stimulus(4'b0100, 1'b0);
    step(6);
    check_output("mid_offer_valid", 32'(valid_a), 32'h1);
    check_output("mid_offer_idx", 32'(idx_a), 32'h2);
    #3 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(valid_a), 32'h0);
    apply_stimulus(4'b0000, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check_output("mid_rst_pending", 32'(pending_a), 32'h0);
    check_output("mid_rst_valid_after", 32'(valid_a), 32'h0);

    begin
      logic [5:0] bounce;
      bounce = 6'b011011;
      for (int s = 0; s < 6; s++) begin
        btn_b[2] = bounce[s];
        step(1);
      end
    end
    btn_b = 4'b0000;
    step(4);
    check_output("bounce_pending", 32'(pending_b), 32'h0);
    check_output("bounce_valid", 32'(valid_b), 32'h0);
    btn_b = 4'b0100;
    step(7);
    check_output("hold_valid", 32'(valid_b), 32'h1);
    check_output("hold_idx", 32'(idx_b), 32'h2);
    check_output("hold_pending", 32'(pending_b), 32'h4);
    ready_b = 1'b1;
    step(1);
    check_output("hold_accept", 32'(valid_b), 32'h0);
    step(5);
    check_output("hold_single", 32'(valid_b), 32'h0);
    check_output("hold_pending_end", 32'(pending_b), 32'h0);
    ready_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
